// File: rtl/coherent_bus_ctrl.sv
// coherent_bus_ctrl -- N-CPU coherent memory bus controller.
//
// Arbitrates instruction fetches, data reads and data writebacks from CPUS
// processors onto one single-ported RAM. Coherent data misses are snooped
// into every other data cache under MSI. Data and instruction requests keep
// separate round-robin pointers.
//
// Optional feature macro: COHERENT_BUS_C2C_EN
//   defined   - a snoop hit is served by a direct cache-to-cache forward
//               combined with one RAM write (C2C state).
//   undefined - a snoop hit becomes a writeback on behalf of the responder
//               followed by a RAM read for the requester.
//
// Ports:
//   CLK, RST                 clock (rising edge), async active-high reset
//   iREN, dREN, dWEN         per-CPU request strobes (held until served)
//   iaddr, daddr, dstore     per-CPU request address / write data
//   ccwrite, cctrans         per-CPU read-exclusive / coherent-miss qualifiers
//   ramload, ramstate        RAM read data and status (FREE/BUSY/ACCESS/ERROR)
//   iwait, dwait             per-CPU "request not complete"
//   iload, dload             per-CPU returned data
//   ccwait, ccinv            per-CPU snoop stall / invalidate
//   ccsnoopaddr              per-CPU snooped address
//   ramREN, ramWEN           RAM strobes (never both high)
//   ramaddr, ramstore        RAM address / write data
module coherent_bus_ctrl #(
  parameter int CPUS   = 2,
  parameter int WORD_W = 32
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic [CPUS-1:0]                iREN,
  input  logic [CPUS-1:0]                dREN,
  input  logic [CPUS-1:0]                dWEN,
  input  logic [CPUS-1:0][WORD_W-1:0]    iaddr,
  input  logic [CPUS-1:0][WORD_W-1:0]    daddr,
  input  logic [CPUS-1:0][WORD_W-1:0]    dstore,
  input  logic [CPUS-1:0]                ccwrite,
  input  logic [CPUS-1:0]                cctrans,
  input  logic [WORD_W-1:0]              ramload,
  input  logic [1:0]                     ramstate,
  output logic [CPUS-1:0]                iwait,
  output logic [CPUS-1:0]                dwait,
  output logic [CPUS-1:0][WORD_W-1:0]    iload,
  output logic [CPUS-1:0][WORD_W-1:0]    dload,
  output logic [CPUS-1:0]                ccwait,
  output logic [CPUS-1:0]                ccinv,
  output logic [CPUS-1:0][WORD_W-1:0]    ccsnoopaddr,
  output logic                           ramREN,
  output logic                           ramWEN,
  output logic [WORD_W-1:0]              ramaddr,
  output logic [WORD_W-1:0]              ramstore
);

  localparam int         PW         = $clog2(CPUS);
  localparam logic [1:0] RAM_ACCESS = 2'd2;

  typedef enum logic [2:0] {
    IDLE, IFETCH, DWB, SNOOP, SNOOP_RSP,
`ifdef COHERENT_BUS_C2C_EN
    C2C,
`endif
    DFILL
  } state_t;

  state_t          state, state_n;
  logic [PW-1:0]   g, g_n;          // granted CPU
  logic [PW-1:0]   r, r_n;          // snoop responder
  logic            wbr, wbr_n;      // DWB is a writeback on behalf of r
  logic [PW-1:0]   dptr, dptr_n;
  logic [PW-1:0]   iptr, iptr_n;
  logic [PW:0]     dsel, isel;      // {found, index}
  logic            done;
  logic            rfound;
  logic [PW-1:0]   rsel;

  // First requester at or after ptr, ascending with wrap. Walking k downward
  // lets the smallest distance win without an explicit found flag.
  function automatic logic [PW:0] pick(input logic [CPUS-1:0] req,
                                       input logic [PW-1:0]   ptr);
    logic [PW:0]   res;
    logic [PW-1:0] sel;
    int            idx;
    res = '0;
    for (int k = CPUS - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= CPUS) idx = idx - CPUS;
      sel = PW'(idx);
      if (req[sel]) res = {1'b1, sel};
    end
    return res;
  endfunction

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    if (int'(p) == CPUS - 1) return '0;
    return p + PW'(1);
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      wbr   <= 1'b0;
      dptr  <= '0;
      iptr  <= '0;
    end else begin
      state <= state_n;
      wbr   <= wbr_n;
      dptr  <= dptr_n;
      iptr  <= iptr_n;
    end
  end

  // Grant and responder only matter outside IDLE, so they carry no reset.
  always_ff @(posedge CLK) begin
    g <= g_n;
    r <= r_n;
  end

  always_comb begin
    state_n     = state;
    g_n         = g;
    r_n         = r;
    wbr_n       = wbr;
    dptr_n      = dptr;
    iptr_n      = iptr;
    iwait       = '1;
    dwait       = '1;
    iload       = '0;
    dload       = '0;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    done        = (ramstate == RAM_ACCESS);
    dsel        = pick(dREN | dWEN, dptr);
    isel        = pick(iREN, iptr);
    rfound      = 1'b0;
    rsel        = '0;
    for (int o = CPUS - 1; o >= 0; o--) begin
      if (dWEN[o] && (PW'(o) != g)) begin
        rfound = 1'b1;
        rsel   = PW'(o);
      end
    end

    // Snoop stall and address stay on the other caches for the whole
    // snoop/forward window; invalidate only pulses in SNOOP.
    if (state == SNOOP || state == SNOOP_RSP
`ifdef COHERENT_BUS_C2C_EN
        || state == C2C
`endif
       ) begin
      for (int o = 0; o < CPUS; o++) begin
        if (PW'(o) != g) begin
          ccwait[o]      = 1'b1;
          ccsnoopaddr[o] = daddr[g];
          ccinv[o]       = (state == SNOOP) ? ccwrite[g] : 1'b0;
        end
      end
    end

    case (state)
      IDLE: begin
        if (dsel[PW]) begin
          g_n   = dsel[PW-1:0];
          wbr_n = 1'b0;
          if (dWEN[g_n])         state_n = DWB;
          else if (cctrans[g_n]) state_n = SNOOP;
          else                   state_n = DFILL;
        end else if (isel[PW]) begin
          g_n     = isel[PW-1:0];
          state_n = IFETCH;
        end
      end
      IFETCH: begin
        ramREN   = 1'b1;
        ramaddr  = iaddr[g];
        iload[g] = ramload;
        if (!iREN[g]) state_n = IDLE;
        else if (done) begin
          iwait[g] = 1'b0;
          state_n  = IDLE;
          iptr_n   = inc(g);
        end
      end
      DWB: begin
        ramWEN   = 1'b1;
        ramaddr  = daddr[g];
        ramstore = wbr ? dstore[r] : dstore[g];
        if (wbr) begin
          // Responder's dirty block goes to RAM first; g then refills.
          if (!dREN[g]) state_n = IDLE;
          else if (done) begin
            dwait[r] = 1'b0;
            wbr_n    = 1'b0;
            state_n  = DFILL;
          end
        end else begin
          if (!dWEN[g]) state_n = IDLE;
          else if (done) begin
            dwait[g] = 1'b0;
            state_n  = IDLE;
            dptr_n   = inc(g);
          end
        end
      end
      SNOOP: begin
        state_n = dREN[g] ? SNOOP_RSP : IDLE;
      end
      SNOOP_RSP: begin
        if (!dREN[g]) state_n = IDLE;
        else if (rfound) begin
          r_n = rsel;
`ifdef COHERENT_BUS_C2C_EN
          state_n = C2C;
`else
          wbr_n   = 1'b1;
          state_n = DWB;
`endif
        end else begin
          state_n = DFILL;
        end
      end
`ifdef COHERENT_BUS_C2C_EN
      C2C: begin
        dload[g] = dstore[r];
        ramWEN   = 1'b1;
        ramaddr  = daddr[g];
        ramstore = dstore[r];
        if (!dREN[g]) state_n = IDLE;
        else if (done) begin
          dwait[g] = 1'b0;
          dwait[r] = 1'b0;
          state_n  = IDLE;
          dptr_n   = inc(g);
        end
      end
`endif
      DFILL: begin
        ramREN   = 1'b1;
        ramaddr  = daddr[g];
        dload[g] = ramload;
        if (!dREN[g]) state_n = IDLE;
        else if (done) begin
          dwait[g] = 1'b0;
          state_n  = IDLE;
          dptr_n   = inc(g);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
